// File: rtl/dispatch_queue.sv
// In-order dispatch FIFO: issues the head bundle to the simple/complex/FP port and sequences fence and trap entries.
// Entries can issue 1 cycle after they are pushed; the head is held until a port accepts it, and in_ready drops when the queue is full.
module dispatch_queue #(
   parameter int DEPTH = 8,
   parameter int PW    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [5:0]                 in_aluop,
   input  logic [1:0]                 in_disp,
   input  logic                       in_fence,
   input  logic                       in_ecall,
   input  logic                       in_ebreak,
   input  logic [PW-1:0]              in_payload,
   output logic                       s_valid,
   input  logic                       s_ready,
   output logic                       c_valid,
   input  logic                       c_ready,
   output logic                       f_valid,
   input  logic                       f_ready,
   output logic [5:0]                 iss_aluop,
   output logic [PW-1:0]              iss_payload,
   input  logic                       pipes_empty,
   output logic                       fence_done,
   output logic                       trap_valid,
   output logic [1:0]                 trap_cause,
   input  logic                       resume,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [5:0]    aluop;
      logic [1:0]    disp;
      logic          fence;
      logic          ecall;
      logic          ebreak;
      logic [PW-1:0] payload;
   } entry_t;

   typedef enum logic [1:0] {
      RUN         = 2'd0,
      FENCE_DRAIN = 2'd1,
      HALT        = 2'd2
   } state_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   state_t          state_q, state_d;
   logic [1:0]      cause_q, cause_d;

   entry_t          head;
   entry_t          in_entry;
   logic            empty;
   logic            push;
   logic            pop;

   always_comb begin
      head     = mem_q[rd_ptr_q];
      empty    = (count_q == '0);
      in_entry = '{aluop: in_aluop, disp: in_disp, fence: in_fence,
                   ecall: in_ecall, ebreak: in_ebreak, payload: in_payload};

      in_ready    = (count_q < CW'(DEPTH)) & ~flush & ~rst;
      push        = in_valid & in_ready;
      pop         = 1'b0;
      s_valid     = 1'b0;
      c_valid     = 1'b0;
      f_valid     = 1'b0;
      fence_done  = 1'b0;
      trap_valid  = 1'b0;
      trap_cause  = 2'b00;
      iss_aluop   = rst ? 6'd0 : head.aluop;
      iss_payload = rst ? '0 : head.payload;
      count       = rst ? '0 : count_q;
      state_d     = state_q;
      cause_d     = cause_q;

      // Nothing issues or retires while reset or flush is asserted.
      if (!rst && !flush) begin
         case (state_q)
            RUN: begin
               if (!empty) begin
                  case (head.disp)
                     2'b10: f_valid = 1'b1;
                     2'b01: c_valid = 1'b1;
                     2'b11: begin
                        s_valid = 1'b1;
                        c_valid = ~s_ready;
                     end
                     default: begin
                        if (head.fence) begin
                           state_d = FENCE_DRAIN;
                        end else begin
                           pop     = 1'b1;
                           state_d = HALT;
                           cause_d = head.ebreak ? 2'b01 : (head.ecall ? 2'b00 : 2'b10);
                        end
                     end
                  endcase
                  if ((s_valid & s_ready) | (c_valid & c_ready) | (f_valid & f_ready)) begin
                     pop = 1'b1;
                  end
               end
            end
            FENCE_DRAIN: begin
               if (pipes_empty) begin
                  pop        = 1'b1;
                  fence_done = 1'b1;
                  state_d    = RUN;
               end
            end
            HALT: begin
               trap_valid = 1'b1;
               trap_cause = cause_q;
               if (resume) begin
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end

      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = in_entry;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         state_d  = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= RUN;
         cause_q  <= 2'b00;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         cause_q  <= cause_d;
      end
   end

   // Storage needs no reset: occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: directed scenarios then random traffic, checked against a queue-based reference model.
module tb_dispatch_queue;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  in_aluop;
   logic [1:0]  in_disp;
   logic        in_fence;
   logic        in_ecall;
   logic        in_ebreak;
   logic [31:0] in_payload;
   logic        s_valid, s_ready;
   logic        c_valid, c_ready;
   logic        f_valid, f_ready;
   logic [5:0]  iss_aluop;
   logic [31:0] iss_payload;
   logic        pipes_empty;
   logic        fence_done;
   logic        trap_valid;
   logic [1:0]  trap_cause;
   logic        resume;
   logic        flush;
   logic [3:0]  count;

   dispatch_queue #(.DEPTH(8), .PW(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_aluop(in_aluop), .in_disp(in_disp),
      .in_fence(in_fence), .in_ecall(in_ecall), .in_ebreak(in_ebreak),
      .in_payload(in_payload),
      .s_valid(s_valid), .s_ready(s_ready),
      .c_valid(c_valid), .c_ready(c_ready),
      .f_valid(f_valid), .f_ready(f_ready),
      .iss_aluop(iss_aluop), .iss_payload(iss_payload),
      .pipes_empty(pipes_empty), .fence_done(fence_done),
      .trap_valid(trap_valid), .trap_cause(trap_cause),
      .resume(resume), .flush(flush), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  aluop;
      logic [1:0]  disp;
      logic        fence;
      logic        ecall;
      logic        ebreak;
      logic [31:0] payload;
   } ent_t;

   localparam int M_RUN   = 0;
   localparam int M_DRAIN = 1;
   localparam int M_HALT  = 2;

   ent_t        mq[$];
   int          mode = M_RUN;
   logic [1:0]  mcause = 2'b00;
   int          tests_run = 0;
   int          tests_failed = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      in_valid   = 1'b0;
      in_disp    = 2'b00;
      in_aluop   = 6'd0;
      in_fence   = 1'b0;
      in_ecall   = 1'b0;
      in_ebreak  = 1'b0;
      in_payload = 32'd0;
      flush      = 1'b0;
      resume     = 1'b0;
   endtask

   task automatic put(input logic [1:0] d, input logic [5:0] a, input logic fe,
                      input logic ec, input logic eb, input logic [31:0] p);
      in_valid   = 1'b1;
      in_disp    = d;
      in_aluop   = a;
      in_fence   = fe;
      in_ecall   = ec;
      in_ebreak  = eb;
      in_payload = p;
   endtask

   // One clock: predict this cycle's outputs from the model, compare, then advance the model at the edge.
   task automatic step();
      ent_t       h;
      ent_t       nw;
      logic       es, ec, ef, efd, etv, eir;
      logic [1:0] etc;
      bit         pop;
      int         nmode;
      logic [1:0] ncause;
      #1;
      eir    = !rst && !flush && (mq.size() < 8);
      es = 0; ec = 0; ef = 0; efd = 0; etv = 0; etc = 2'b00;
      pop    = 0;
      nmode  = mode;
      ncause = mcause;
      if (!rst && !flush) begin
         if (mode == M_HALT) begin
            etv = 1; etc = mcause;
            if (resume) nmode = M_RUN;
         end else if (mode == M_DRAIN) begin
            if (pipes_empty) begin efd = 1; pop = 1; nmode = M_RUN; end
         end else if (mq.size() > 0) begin
            h = mq[0];
            case (h.disp)
               2'b10: begin ef = 1; pop = f_ready; end
               2'b01: begin ec = 1; pop = c_ready; end
               2'b11: begin es = 1; ec = !s_ready; pop = s_ready || c_ready; end
               default: begin
                  if (h.fence) nmode = M_DRAIN;
                  else begin
                     pop = 1; nmode = M_HALT;
                     ncause = h.ebreak ? 2'b01 : (h.ecall ? 2'b00 : 2'b10);
                  end
               end
            endcase
         end
      end
      check("in_ready", 64'(in_ready), 64'(eir));
      check("count", 64'(count), 64'(rst ? 0 : mq.size()));
      check("fence_done", 64'(fence_done), 64'(efd));
      if (!flush) begin
         check("s_valid", 64'(s_valid), 64'(es));
         check("c_valid", 64'(c_valid), 64'(ec));
         check("f_valid", 64'(f_valid), 64'(ef));
         check("trap_valid", 64'(trap_valid), 64'(etv));
         if (rst || etv) check("trap_cause", 64'(trap_cause), 64'(etc));
      end
      if (rst) begin
         check("iss_aluop_rst", 64'(iss_aluop), 64'd0);
         check("iss_payload_rst", 64'(iss_payload), 64'd0);
      end else if (!flush && (es || ec || ef)) begin
         check("iss_aluop", 64'(iss_aluop), 64'(h.aluop));
         check("iss_payload", 64'(iss_payload), 64'(h.payload));
      end
      nw = '{aluop: in_aluop, disp: in_disp, fence: in_fence, ecall: in_ecall,
             ebreak: in_ebreak, payload: in_payload};
      @(posedge clk);
      if (rst || flush) begin
         mq.delete();
         mode = M_RUN;
      end else begin
         if (pop) void'(mq.pop_front());
         if (in_valid && eir) mq.push_back(nw);
         mode   = nmode;
         mcause = ncause;
      end
      @(negedge clk);
   endtask

   initial begin
      idle();
      rst = 1'b1; s_ready = 0; c_ready = 0; f_ready = 0; pipes_empty = 0;
      @(negedge clk);
      step(); step();
      rst = 1'b0;
      step();

      // Three classes back to back with every port ready.
      s_ready = 1; c_ready = 1; f_ready = 1;
      put(2'b11, 6'h00, 0, 0, 0, 32'hA000_0001); step();
      put(2'b01, 6'h16, 0, 0, 0, 32'hA000_0002); step();
      put(2'b10, 6'h34, 0, 0, 0, 32'hA000_0003); step();
      idle(); step(); step();
      check("t1_count_zero", 64'(count), 64'd0);

      // Dual-class entry steered to complex, then held with both ports stalled.
      s_ready = 0; c_ready = 1; f_ready = 0;
      put(2'b11, 6'h2A, 0, 0, 0, 32'hB000_0001); step();
      idle(); step(); step();
      c_ready = 0;
      put(2'b11, 6'h2B, 0, 0, 0, 32'hB000_0002); step();
      idle(); step(); step();
      check("t2_held_count", 64'(count), 64'd1);
      s_ready = 1; step(); step();

      // Fill, pop-only on full, then steady push/pop across pointer wrap.
      s_ready = 0; c_ready = 0; f_ready = 0;
      for (int i = 0; i < 8; i++) begin
         put(2'b10, 6'(i), 0, 0, 0, 32'hC000_0000 + 32'(i)); step();
      end
      check("t3_full_count", 64'(count), 64'd8);
      check("t3_full_in_ready", 64'(in_ready), 64'd0);
      f_ready = 1;
      put(2'b10, 6'h3F, 0, 0, 0, 32'hC000_00FF); step();
      check("t3_after_pop_count", 64'(count), 64'd7);
      for (int i = 0; i < 16; i++) begin
         put(2'b10, 6'(i + 8), 0, 0, 0, $urandom); step();
      end
      idle();
      for (int i = 0; i < 9; i++) step();

      // Fence drain waits for pipes_empty, retires with a one-cycle pulse.
      s_ready = 1; c_ready = 1; f_ready = 1; pipes_empty = 0;
      put(2'b00, 6'h05, 1, 0, 0, 32'hD000_0001); step();
      put(2'b11, 6'h06, 0, 0, 0, 32'hD000_0002); step();
      idle();
      for (int i = 0; i < 5; i++) step();
      pipes_empty = 1; step();
      pipes_empty = 0; step(); step();

      // ebreak halts with entries held behind it; resume releases them.
      put(2'b00, 6'h07, 0, 1, 1, 32'hE000_0001); step();
      put(2'b01, 6'h08, 0, 0, 0, 32'hE000_0002); step();
      put(2'b10, 6'h09, 0, 0, 0, 32'hE000_0003); step();
      idle(); step(); step();
      check("t5_halt_cause", 64'(trap_cause), 64'd1);
      resume = 1; step();
      resume = 0; step(); step(); step();
      put(2'b00, 6'h0A, 0, 0, 0, 32'hE000_0004); step();
      put(2'b11, 6'h0B, 0, 0, 0, 32'hE000_0005); step();
      idle(); step(); step();
      check("t5_illegal_cause", 64'(trap_cause), 64'd2);
      resume = 1; step();
      resume = 0; step(); step();

      // Flush while halted with five entries queued.
      s_ready = 0; c_ready = 0; f_ready = 0;
      put(2'b00, 6'h0C, 0, 1, 0, 32'hF000_0000); step();
      for (int i = 0; i < 5; i++) begin
         put(2'b01, 6'(i), 0, 0, 0, 32'hF000_0001 + 32'(i)); step();
      end
      idle();
      check("t6_halt_count", 64'(count), 64'd5);
      check("t6_halt_trap", 64'(trap_valid), 64'd1);
      flush = 1; step();
      flush = 0;
      check("t6_flush_count", 64'(count), 64'd0);
      check("t6_flush_trap", 64'(trap_valid), 64'd0);
      step();

      // Reset in the middle of a fence drain.
      put(2'b00, 6'h11, 1, 0, 0, 32'h1234_5678); step();
      idle(); step(); step();
      rst = 1; step(); step();
      rst = 0; step();

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         in_valid    = 1'($urandom_range(0, 1));
         in_disp     = 2'($urandom_range(0, 3));
         in_aluop    = 6'($urandom);
         in_payload  = $urandom;
         in_fence    = ($urandom_range(0, 3) == 0);
         in_ecall    = ($urandom_range(0, 2) == 0);
         in_ebreak   = ($urandom_range(0, 2) == 0);
         s_ready     = 1'($urandom_range(0, 1));
         c_ready     = 1'($urandom_range(0, 1));
         f_ready     = 1'($urandom_range(0, 1));
         pipes_empty = ($urandom_range(0, 2) == 0);
         resume      = ($urandom_range(0, 5) == 0);
         flush       = ($urandom_range(0, 59) == 0);
         step();
      end
      idle();
      step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
